cla_seq_ctrl: RTL and testbench
===============================

# cla_seq_ctrl

Multi-cycle sequencer that performs wide (LIMB×LIMBS-bit) add/subtract by time-multiplexing one narrow CLA adder over successive limbs, least significant first. The carry is registered between beats. It sits between the ALU issue logic and the result writeback, and uses a valid/ready handshake on both sides. It exists so wide integer and mantissa operations can reuse one LIMB-bit CLA instead of a full-width adder.

## Interface
- LIMB, 32, width of the shared CLA instance (bits per beat)
- LIMBS, 4, number of limbs per operation; must be ≥ 2
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request (state IDLE)
- op_a  in  LIMB*LIMBS  operand A
- op_b  in  LIMB*LIMBS  operand B
- sub  in  1  1 = A − B, 0 = A + B
- out_valid  out  1  result held, waiting for consumer
- out_ready  in  1  consumer accepts result
- result  out  LIMB*LIMBS  sum/difference
- cout  out  1  final carry out (for subtract: 1 = no borrow)
- ovf  out  1  two's-complement signed overflow
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: in_ready=1. When in_valid=1, capture op_a, op_b and sub. Set carry ← sub, beat ← 0, go to RUN.
- RUN, each cycle:
  - Drive CLA A = a limb[beat], B = b limb[beat] XOR {LIMB{sub}}, CIN = carry.
  - result limb[beat] ← SUM; carry ← COUT; beat ← beat+1.
  - When beat = LIMBS−1: cout ← COUT, ovf ← (a_msb == b'_msb) & (SUM_msb ≠ a_msb), where b' is the inverted B for subtract. Go to DONE.
- ovf is computed locally from top-limb MSBs. The CLA OVF port is left unconnected.
- DONE: out_valid=1. result, cout and ovf are held stable. On out_ready=1 → IDLE and out_valid drops the next cycle.
- in_valid outside IDLE is ignored; in_ready=0 in RUN and DONE.
- beat counter width is $clog2(LIMBS). It never wraps past LIMBS−1.
- Result limbs not yet written in RUN retain their previous values. They are undefined-for-use until out_valid.
- Reset at any time, including mid-RUN: the operation is aborted with no out_valid. State → IDLE. result, cout, ovf, carry, beat and operand registers are cleared to 0.

## Timing
- Reset values:
  - out_valid=0, result=0, cout=0, ovf=0, busy=0.
  - in_ready=1 once in IDLE.
- in_ready and busy are decoded combinationally from state. All other outputs are registered.
- Latency: request accepted at edge T → out_valid=1 after edge T+LIMBS.
- Throughput: out_ready held high gives one operation per LIMBS+2 cycles (IDLE, LIMBS×RUN, DONE).
- Critical path: one LIMB-bit CLA ripple plus the B inversion mux. The carry register breaks the path between limbs.

## Configuration
- CLA_SEQ_SUB_EN defined:
  - sub is honoured: B is inverted and initial carry = sub.
- CLA_SEQ_SUB_EN undefined:
  - sub port remains but is ignored.
  - B is never inverted and initial carry = 0; the inversion XOR is not synthesised.
  - ovf = (a_msb == b_msb) & (SUM_msb ≠ a_msb).

## Structure
- Shared package cla_seq_pkg:
  - state enum (IDLE, RUN, DONE)
  - default LIMB/LIMBS constants
  - a function extracting limb k from a packed word
- One sub-module: the existing CLA adder, instantiated once with size = LIMB. All sequencing logic lives in cla_seq_ctrl.

## Test plan
Scenarios 1–5 use defaults (LIMB=32, LIMBS=4); scenario 6 uses LIMBS=2.
1. All-ones 128-bit + 1, sub=0 → result 0, cout=1, ovf=0. out_valid exactly 4 cycles after the accept edge.
2. 0x7FFF…FFFF + 1 → result 0x8000_0000_…_0000, cout=0, ovf=1.
3. Subtract (CLA_SEQ_SUB_EN defined): 0 − 1 → result all-ones, cout=0, ovf=0. Then 5 − 3 → result 2, cout=1.
4. Carry across limbs: A=0x0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, B=1 → result 0x0000_0001_0000_…_0000, cout=0.
5. Backpressure: out_ready=0 for 10 cycles in DONE, new in_valid pulsed → result stable, in_ready=0, request ignored. out_ready=1 → IDLE next cycle, then the next op is accepted.
6. LIMBS=2, rst pulsed during RUN beat 1 → all outputs 0, state IDLE, no out_valid. A following 3+4 returns 7.

Source files
------------

// File: rtl/cla_seq_pkg.sv
// cla_seq_pkg: shared state encoding, default sizes and limb extraction for the CLA sequencer
package cla_seq_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int LIMB_DEF = 32;
    localparam int LIMBS_DEF = 4;
    function automatic logic [LIMB_DEF-1:0] limb_of(input logic [LIMB_DEF*LIMBS_DEF-1:0] w, input int k);
        return w[k*LIMB_DEF +: LIMB_DEF];
    endfunction
endpackage

// File: rtl/cla_seq_if.sv
// cla_seq_if: request/result handshake bundle; master issues and consumes, slave is the sequencer
interface cla_seq_if #(parameter int W = cla_seq_pkg::LIMB_DEF * cla_seq_pkg::LIMBS_DEF);
    logic in_valid, in_ready, sub, out_valid, out_ready, cout, ovf, busy;
    logic [W-1:0] op_a, op_b, result;
    modport master(output in_valid, op_a, op_b, sub, out_ready,
                   input in_ready, out_valid, result, cout, ovf, busy);
    modport slave(input in_valid, op_a, op_b, sub, out_ready,
                  output in_ready, out_valid, result, cout, ovf, busy);
endinterface

// File: rtl/cla_seq_cla.sv
// cla_adder: SIZE-bit adder built from generate/propagate terms, shared by the sequencer
module cla_adder #(parameter int SIZE = 32) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            cin,
    output logic [SIZE-1:0] sum,
    output logic            cout,
    output logic            ovf
);
    logic [SIZE-1:0] g, p;
    logic [SIZE:0] c;
    assign g = a & b;
    assign p = a ^ b;
    always_comb begin
        c[0] = cin;
        for (int i = 0; i < SIZE; i++) c[i+1] = g[i] | (p[i] & c[i]);
    end
    assign sum = p ^ c[SIZE-1:0];
    assign cout = c[SIZE];
    assign ovf = c[SIZE] ^ c[SIZE-1];
endmodule

// File: rtl/cla_seq_ctrl.sv
// cla_seq_ctrl: wide add/subtract by stepping one LIMB-bit CLA over LIMBS limbs, LSB limb first.
// Define CLA_SEQ_SUB_EN to honour the sub input; otherwise every operation is an add.
module cla_seq_ctrl
    import cla_seq_pkg::*;
#(
    parameter int LIMB = LIMB_DEF,
    parameter int LIMBS = LIMBS_DEF
) (
    input logic clk,
    input logic rst,
    cla_seq_if.slave bus
);
    localparam int W = LIMB * LIMBS;
    localparam int BW = $clog2(LIMBS);
    state_t state;
    logic [W-1:0] a_q, b_q, res_q;
    logic [BW-1:0] beat;
    logic carry, cout_q, ovf_q, out_valid_q;
    logic [LIMB-1:0] cla_a, cla_b, cla_sum;
    logic cla_cout;
    assign cla_a = a_q[beat*LIMB +: LIMB];
`ifdef CLA_SEQ_SUB_EN
    logic sub_q;
    assign cla_b = b_q[beat*LIMB +: LIMB] ^ {LIMB{sub_q}};
`else
    assign cla_b = b_q[beat*LIMB +: LIMB];
`endif
    cla_adder #(.SIZE(LIMB)) u_cla (
        .a(cla_a), .b(cla_b), .cin(carry), .sum(cla_sum), .cout(cla_cout), .ovf()
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_q <= '0;
            b_q <= '0;
            res_q <= '0;
            beat <= '0;
            carry <= 1'b0;
            cout_q <= 1'b0;
            ovf_q <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef CLA_SEQ_SUB_EN
            sub_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    a_q <= bus.op_a;
                    b_q <= bus.op_b;
                    beat <= '0;
                    state <= RUN;
`ifdef CLA_SEQ_SUB_EN
                    sub_q <= bus.sub;
                    carry <= bus.sub;
`else
                    carry <= 1'b0;
`endif
                end
                RUN: begin
                    res_q[beat*LIMB +: LIMB] <= cla_sum;
                    carry <= cla_cout;
                    // cla_b already carries the subtract inversion, so one overflow rule serves both ops
                    if (beat == BW'(LIMBS - 1)) begin
                        cout_q <= cla_cout;
                        ovf_q <= (cla_a[LIMB-1] == cla_b[LIMB-1]) & (cla_sum[LIMB-1] != cla_a[LIMB-1]);
                        out_valid_q <= 1'b1;
                        state <= DONE;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                DONE: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.in_ready = state == IDLE;
    assign bus.busy = state != IDLE;
    assign bus.out_valid = out_valid_q;
    assign bus.result = res_q;
    assign bus.cout = cout_q;
    assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_cla_seq_ctrl.sv
// tb_cla_seq_ctrl: directed table, backpressure, mid-RUN reset and randomized ops against an arithmetic model
module tb_cla_seq_ctrl;
    import cla_seq_pkg::*;
    localparam int W = LIMB_DEF * LIMBS_DEF;
    localparam int W2 = LIMB_DEF * 2;
`ifdef CLA_SEQ_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic s;
        logic [W-1:0] res;
        logic co;
        logic ov;
    } vec_t;

    logic clk = 1'b0, rst = 1'b0, rst2 = 1'b0;
    int n_cmp = 0, n_err = 0;
    always #5 clk = ~clk;

    cla_seq_if #(.W(W)) m4();
    cla_seq_if #(.W(W2)) m2();
    cla_seq_ctrl #(.LIMB(LIMB_DEF), .LIMBS(LIMBS_DEF)) dut4 (.clk(clk), .rst(rst), .bus(m4.slave));
    cla_seq_ctrl #(.LIMB(LIMB_DEF), .LIMBS(2)) dut2 (.clk(clk), .rst(rst2), .bus(m2.slave));

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // reference: plain wide arithmetic, signed overflow from a one-bit-wider signed result
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] r, output logic co, output logic ov);
        logic [W:0] u;
        logic signed [W:0] sa, sb, sr;
        sa = $signed({a[W-1], a});
        sb = $signed({b[W-1], b});
        if (SUB_EN && s) begin
            u = {1'b0, a} - {1'b0, b};
            co = a >= b;
            sr = sa - sb;
        end else begin
            u = {1'b0, a} + {1'b0, b};
            co = u[W];
            sr = sa + sb;
        end
        r = u[W-1:0];
        ov = sr[W] != sr[W-1];
    endfunction

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] r, output logic co, output logic ov, output int lat);
        @(negedge clk);
        m4.op_a = a;
        m4.op_b = b;
        m4.sub = s;
        m4.in_valid = 1'b1;
        @(posedge clk);
        #1;
        m4.in_valid = 1'b0;
        lat = 0;
        while (!m4.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r = m4.result;
        co = m4.cout;
        ov = m4.ovf;
        m4.out_ready = 1'b1;
        @(posedge clk);
        #1;
        m4.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl[8];
        logic [W-1:0] ones, msb, r, er, hold;
        logic co, ov, eco, eov;
        int lat, seen;
        ones = '1;
        msb = {1'b1, {(W-1){1'b0}}};
        tbl[0] = '{ones, W'(1), 1'b0, '0, 1'b1, 1'b0};
        tbl[1] = '{~msb, W'(1), 1'b0, msb, 1'b0, 1'b1};
        if (SUB_EN) begin
            tbl[2] = '{'0, W'(1), 1'b1, ones, 1'b0, 1'b0};
            tbl[3] = '{W'(5), W'(3), 1'b1, W'(2), 1'b1, 1'b0};
            tbl[7] = '{msb, W'(1), 1'b1, ~msb, 1'b1, 1'b1};
        end else begin
            tbl[2] = '{'0, W'(1), 1'b1, W'(1), 1'b0, 1'b0};
            tbl[3] = '{W'(5), W'(3), 1'b1, W'(8), 1'b0, 1'b0};
            tbl[7] = '{msb, W'(1), 1'b1, msb | W'(1), 1'b0, 1'b0};
        end
        tbl[4] = '{{32'h0, {96{1'b1}}}, W'(1), 1'b0, {32'h1, 96'h0}, 1'b0, 1'b0};
        tbl[5] = '{ones, ones, 1'b0, ~W'(1), 1'b1, 1'b0};
        tbl[6] = '{msb, msb, 1'b0, '0, 1'b1, 1'b1};

        {m4.in_valid, m4.op_a, m4.op_b, m4.sub, m4.out_ready} = '0;
        {m2.in_valid, m2.op_a, m2.op_b, m2.sub, m2.out_ready} = '0;
        #1;
        rst = 1'b1;
        rst2 = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", W'(m4.out_valid), '0);
        chk("rst_result", m4.result, '0);
        chk("rst_cout_ovf", W'({m4.cout, m4.ovf}), '0);
        chk("rst_busy", W'(m4.busy), '0);
        chk("rst_in_ready", W'(m4.in_ready), W'(1));
        rst = 1'b0;
        rst2 = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].s, r, co, ov, lat);
            chk($sformatf("vec%0d_result", i), r, tbl[i].res);
            chk($sformatf("vec%0d_cout", i), W'(co), W'(tbl[i].co));
            chk($sformatf("vec%0d_ovf", i), W'(ov), W'(tbl[i].ov));
            chk($sformatf("vec%0d_latency", i), W'(lat), W'(LIMBS_DEF));
            if (i == 4) chk("vec4_top_limb", W'(limb_of(r, 3)), W'(1));
        end

        // backpressure: result held while DONE, stray request ignored
        @(negedge clk);
        m4.op_a = W'(100);
        m4.op_b = W'(23);
        m4.sub = 1'b0;
        m4.in_valid = 1'b1;
        @(posedge clk);
        #1;
        m4.in_valid = 1'b0;
        lat = 0;
        while (!m4.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("bp_latency", W'(lat), W'(LIMBS_DEF));
        hold = m4.result;
        chk("bp_result", hold, W'(123));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d", k), m4.result, hold);
            chk($sformatf("bp_in_ready%0d", k), W'({m4.in_ready, m4.out_valid}), W'(1));
            m4.in_valid = k == 3;
            m4.op_a = ones;
            m4.op_b = ones;
        end
        @(negedge clk);
        m4.in_valid = 1'b0;
        m4.out_ready = 1'b1;
        @(posedge clk);
        #1;
        m4.out_ready = 1'b0;
        chk("bp_release", W'({m4.out_valid, m4.in_ready, m4.busy}), W'(3'b010));
        do_op(W'(40), W'(2), 1'b0, r, co, ov, lat);
        chk("bp_next_result", r, W'(42));
        chk("bp_next_latency", W'(lat), W'(LIMBS_DEF));

        // LIMBS=2: reset in beat 1 aborts, then a clean 3+4
        @(negedge clk);
        m2.op_a = 64'hFFFF_FFFF_0000_0005;
        m2.op_b = 64'h0000_0001_0000_0009;
        m2.sub = 1'b0;
        m2.in_valid = 1'b1;
        @(posedge clk);
        #1;
        m2.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("l2_busy_beat1", W'(m2.busy), W'(1));
        rst2 = 1'b1;
        #1;
        chk("l2_rst_out_valid", W'(m2.out_valid), '0);
        chk("l2_rst_result", W'(m2.result), '0);
        chk("l2_rst_cout_ovf", W'({m2.cout, m2.ovf}), '0);
        chk("l2_rst_idle", W'({m2.busy, m2.in_ready}), W'(2'b01));
        @(negedge clk);
        rst2 = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (m2.out_valid) seen++;
        end
        chk("l2_no_out_valid", W'(seen), '0);
        m2.op_a = 64'd3;
        m2.op_b = 64'd4;
        m2.in_valid = 1'b1;
        @(posedge clk);
        #1;
        m2.in_valid = 1'b0;
        lat = 0;
        while (!m2.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("l2_latency", W'(lat), W'(2));
        chk("l2_result", W'(m2.result), W'(7));
        m2.out_ready = 1'b1;
        @(posedge clk);
        #1;
        m2.out_ready = 1'b0;

        // randomized against the arithmetic model
        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] a, b;
            logic s;
            a = {$urandom, $urandom, $urandom, $urandom};
            b = {$urandom, $urandom, $urandom, $urandom};
            s = 1'($urandom_range(0, 1));
            if (i % 5 == 0) b = ~a;
            if (i % 7 == 0) a = ones;
            if (i % 11 == 0) b = a;
            model(a, b, s, er, eco, eov);
            do_op(a, b, s, r, co, ov, lat);
            chk($sformatf("rnd%0d_result", i), r, er);
            chk($sformatf("rnd%0d_flags", i), W'({co, ov}), W'({eco, eov}));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
